// File: rtl/polar_encoder_if.sv
// Handshake bundle for the polar encoder: serial info-bit input, parallel codeword output.
interface polar_encoder_if #(
    parameter int N = 8
) ();
    logic         in_valid;
    logic         in_ready;
    logic         in_bit;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_code;
    logic         busy;

    modport master (
        output in_valid, in_bit, out_ready,
        input  in_ready, out_valid, out_code, busy
    );

    modport slave (
        input  in_valid, in_bit, out_ready,
        output in_ready, out_valid, out_code, busy
    );
endinterface

// File: rtl/polar_encoder.sv
// Iterative polar encoder: x = u * F^(kron n), one butterfly stage per clock.
// Optional macro POLAR_ENC_BITREV_EN presents the codeword in bit-reversed order.
module polar_encoder #(
    parameter int           N           = 8,
    parameter int           LOG_N       = 3,
    parameter int           K           = 4,
    parameter logic [N-1:0] FROZEN_MASK = 8'h17
) (
    input  logic           clk,
    input  logic           rst,
    polar_encoder_if.slave bus
);
    localparam int SW = (LOG_N > 1) ? $clog2(LOG_N) : 1;

    function automatic int first_free();
        int r = 0;
        for (int i = N - 1; i >= 0; i--)
            if (!FROZEN_MASK[i]) r = i;
        return r;
    endfunction

    function automatic int last_free();
        int r = 0;
        for (int i = 0; i < N; i++)
            if (!FROZEN_MASK[i]) r = i;
        return r;
    endfunction

    function automatic int count_free();
        int r = 0;
        for (int i = 0; i < N; i++)
            if (!FROZEN_MASK[i]) r++;
        return r;
    endfunction

    function automatic int bitrev(input int idx);
        int r = 0;
        for (int b = 0; b < LOG_N; b++)
            if (((idx >> b) & 1) == 1) r = r | (1 << (LOG_N - 1 - b));
        return r;
    endfunction

    localparam logic [LOG_N-1:0] FIRST_FREE = LOG_N'(first_free());
    localparam logic [LOG_N-1:0] LAST_FREE  = LOG_N'(last_free());

    if (count_free() != K) begin : g_bad_k
        $error("polar_encoder: FROZEN_MASK leaves %0d free positions, K is %0d", count_free(), K);
    end
    if ((1 << LOG_N) != N) begin : g_bad_logn
        $error("polar_encoder: LOG_N %0d does not match N %0d", LOG_N, N);
    end

    typedef enum logic [1:0] {LOAD, ENC, OUT} state_t;

    state_t           state_reg, state_next;
    logic [N-1:0]     u_reg, u_next;
    logic [LOG_N-1:0] ptr_reg, ptr_next, ptr_adv;
    logic [SW-1:0]    stage_reg, stage_next;
    logic [N-1:0]     stage_res [LOG_N];
    logic [N-1:0]     code_perm;

    // Partner index j | 2^s equals j itself when bit s is set, so every index stays in range.
    for (genvar gi = 0; gi < LOG_N; gi++) begin : g_stage
        logic [N-1:0] res;
        always_comb begin
            res = '0;
            for (int j = 0; j < N; j++)
                res[j] = (((j >> gi) & 1) == 1) ? u_reg[j] : (u_reg[j] ^ u_reg[j | (1 << gi)]);
        end
        assign stage_res[gi] = res;
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_perm
`ifdef POLAR_ENC_BITREV_EN
        assign code_perm[gi] = u_reg[bitrev(gi)];
`else
        assign code_perm[gi] = u_reg[gi];
`endif
    end

    // Lowest non-frozen index above the current pointer.
    always_comb begin
        ptr_adv = ptr_reg;
        for (int i = N - 1; i >= 0; i--)
            if (i > int'(ptr_reg) && !FROZEN_MASK[i]) ptr_adv = LOG_N'(i);
    end

    always_comb begin
        state_next = state_reg;
        u_next     = u_reg;
        ptr_next   = ptr_reg;
        stage_next = stage_reg;
        case (state_reg)
            LOAD: begin
                if (bus.in_valid) begin
                    u_next[ptr_reg] = bus.in_bit;
                    ptr_next        = ptr_adv;
                    if (ptr_reg == LAST_FREE) begin
                        state_next = ENC;
                        stage_next = '0;
                    end
                end
            end
            ENC: begin
                u_next     = stage_res[stage_reg];
                stage_next = stage_reg + 1'b1;
                if (stage_reg == SW'(LOG_N - 1)) begin
                    state_next = OUT;
                    stage_next = '0;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    u_next     = '0;
                    ptr_next   = FIRST_FREE;
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= LOAD;
            u_reg     <= '0;
            ptr_reg   <= FIRST_FREE;
            stage_reg <= '0;
        end else begin
            state_reg <= state_next;
            u_reg     <= u_next;
            ptr_reg   <= ptr_next;
            stage_reg <= stage_next;
        end
    end

    assign bus.in_ready  = (state_reg == LOAD);
    assign bus.out_valid = (state_reg == OUT);
    assign bus.busy      = (state_reg != LOAD);
    assign bus.out_code  = (state_reg == OUT) ? code_perm : '0;
endmodule

// File: tb/tb_polar_encoder.sv
// Self-checking bench for polar_encoder: directed vectors, backpressure, resets, random frames.
module tb_polar_encoder;
    localparam int           N     = 8;
    localparam int           LOG_N = 3;
    localparam int           K     = 4;
    localparam logic [N-1:0] MASK  = 8'h17;

`ifdef POLAR_ENC_BITREV_EN
    localparam logic [N-1:0] EXP_1000 = 8'h55;
`else
    localparam logic [N-1:0] EXP_1000 = 8'h0F;
`endif
    localparam logic [N-1:0] EXP_1111 = 8'h96;
    localparam logic [N-1:0] EXP_0001 = 8'hFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    polar_encoder_if #(.N(N)) bus ();

    polar_encoder #(.N(N), .LOG_N(LOG_N), .K(K), .FROZEN_MASK(MASK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int hs_count = 0;
    int frames   = 0;

    always @(posedge clk)
        if (!rst && bus.out_valid && bus.out_ready) hs_count <= hs_count + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: x_j = XOR of u_i over i whose bit set contains j's bit set.
    function automatic logic [N-1:0] model(input logic [K-1:0] info);
        logic [N-1:0] u = '0;
        logic [N-1:0] x = '0;
        logic [N-1:0] o = '0;
        int p = 0;
        for (int i = 0; i < N; i++)
            if (!MASK[i]) begin
                u[i] = info[p];
                p++;
            end
        for (int j = 0; j < N; j++)
            for (int i = 0; i < N; i++)
                if ((j & ~i) == 0) x[j] = x[j] ^ u[i];
`ifdef POLAR_ENC_BITREV_EN
        for (int i = 0; i < N; i++) begin
            int r = 0;
            for (int b = 0; b < LOG_N; b++)
                if (((i >> b) & 1) == 1) r = r + (1 << (LOG_N - 1 - b));
            o[i] = x[r];
        end
`else
        o = x;
`endif
        return o;
    endfunction

    // Drives the first cnt bits of info (info[0] first); returns at the negedge after the last accept.
    task automatic send_bits(input logic [K-1:0] info, input int cnt, input int max_gap);
        for (int p = 0; p < cnt; p++) begin
            int gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gaps; g++) begin
                bus.in_valid = 1'b0;
                bus.in_bit   = 1'($urandom);
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_bit   = info[p];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input string tag);
        int lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, LOG_N);
    endtask

    task automatic pop(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check({tag, "_valid_drop"}, bus.out_valid, 1'b0);
        check({tag, "_ready_back"}, bus.in_ready, 1'b1);
        frames++;
    endtask

    task automatic do_frame(input string tag, input logic [K-1:0] info, input logic [N-1:0] exp);
        send_bits(info, K, 0);
        wait_out(tag);
        check({tag, "_code"}, bus.out_code, exp);
        pop(tag);
        bus.out_ready = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_in_ready"},  bus.in_ready,  1'b1);
        check({tag, "_out_valid"}, bus.out_valid, 1'b0);
        check({tag, "_busy"},      bus.busy,      1'b0);
        check({tag, "_out_code"},  bus.out_code,  '0);
    endtask

    initial begin
        logic [N-1:0] held;
        logic [K-1:0] info;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bit    = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        do_frame("vec_1000", 4'b0001, EXP_1000);
        do_frame("vec_1111", 4'b1111, EXP_1111);
        do_frame("vec_0001", 4'b1000, EXP_0001);

        // Backpressure with junk on the input side.
        send_bits(4'b0101, K, 0);
        wait_out("bp");
        held = bus.out_code;
        check("bp_code", held, model(4'b0101));
        for (int c = 0; c < 10; c++) begin
            bus.in_valid = 1'b1;
            bus.in_bit   = c[0];
            @(negedge clk);
            check("bp_hold_code",  bus.out_code,  held);
            check("bp_hold_valid", bus.out_valid, 1'b1);
            check("bp_hold_ready", bus.in_ready,  1'b0);
        end
        bus.in_valid = 1'b0;
        pop("bp");
        bus.out_ready = 1'b0;
        do_frame("bp_next", 4'b1000, EXP_0001);

        // Reset after two of four info bits.
        send_bits(4'b1111, 2, 0);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_load");
        rst = 1'b0;
        do_frame("after_rst_load", 4'b1000, EXP_0001);

        // Reset during butterfly stage 1.
        send_bits(4'b1111, K, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset("rst_enc");
        rst = 1'b0;
        do_frame("after_rst_enc", 4'b1000, EXP_0001);

        // Random frames with input gaps, out_ready tied high.
        bus.out_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            info = K'($urandom);
            send_bits(info, K, 3);
            wait_out("rand");
            check("rand_code", bus.out_code, model(info));
            pop("rand");
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("handshake_count", hs_count, frames);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/polar_encoder.md
Name: polar_encoder

Overview:
Iterative polar encoder. It is the transmit-side counterpart of the min-sum BP polar decoder datapath.
- Collects K information bits serially over a valid/ready handshake.
- Inserts zeros at the frozen positions.
- Computes x = u·F^{⊗n} with one butterfly stage per clock.
- Presents the N-bit codeword in parallel over a valid/ready handshake.
- Feeds the channel model / LLR generator in front of the BP decoder.

Parameters:
- N, 8, code length; power of two, 4..1024.
- LOG_N, 3, log2(N); must match N.
- K, 4, number of information bits, 1..N.
- FROZEN_MASK, 8'h17, N-bit mask; bit i=1 means u[i] is frozen (forced 0). Popcount of ~FROZEN_MASK must equal K. Simulation-time check issues $error on mismatch.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  info bit valid.
- in_ready  output  1  encoder can accept an info bit.
- in_bit  input  1  info bit; first accepted bit goes to the lowest non-frozen index.
- out_valid  output  1  codeword valid.
- out_ready  input  1  downstream accepts codeword.
- out_code  output  N  codeword; out_code[i] = x_i.
- busy  output  1  high when not in LOAD.

Behaviour:
- One clock, synchronous active-high reset. rst is sampled on the rising edge of clk and overrides every other input in any state.
- State after reset: LOAD, u register = 0, info pointer = lowest non-frozen index, stage counter = 0.
- Output values after reset: in_ready=1, out_valid=0, busy=0, out_code=0.
- States: LOAD, ENC, OUT. Encoding is a registered FSM.
- LOAD:
  - in_ready=1.
  - On in_valid&in_ready: u[ptr] <= in_bit; ptr advances to the next index whose FROZEN_MASK bit is 0.
  - Frozen entries of u stay 0.
  - Gaps in in_valid are allowed; no timeout.
  - On acceptance of the K-th bit: state -> ENC, stage=0.
- ENC:
  - in_ready=0.
  - Each cycle at stage s (0..LOG_N-1): for every j with bit s of j equal 0, u[j] <= u[j] ^ u[j+2^s].
  - stage increments each cycle; after stage LOG_N-1, state -> OUT.
- Result: x_j = XOR of u_i over all i with (j & ~i)==0 (natural order, no bit reversal).
- Latency: out_valid rises LOG_N cycles after the edge that accepted the K-th bit.
- OUT:
  - out_valid=1, out_code=u register.
  - out_code is held stable while out_valid & ~out_ready, for any length of backpressure.
  - On out_valid&out_ready: u cleared, ptr reset, state -> LOAD. in_ready goes to 1 on the following cycle.
- in_valid/in_bit are ignored in ENC and OUT; no bits are buffered.
- Reset mid-operation (LOAD/ENC/OUT): partial frame discarded, out_valid drops on that edge, and all values return to reset state.
- Throughput: one codeword per K + LOG_N + 1 cycles minimum, with out_ready tied high.

Optional Feature:
- Macro: POLAR_ENC_BITREV_EN.
- Defined: output stage applies the bit-reversal permutation, out_code[i] = x[bitrev_LOG_N(i)].
  - The permutation is a pure wire mapping.
  - No latency change.
- Undefined: out_code[i] = x_i (natural order).
- The handshake and FSM are identical either way.

Test Plan:
- Defaults, macro off, in_bit sequence 1,0,0,0 (u3=1) -> out_code = 8'h0F; out_valid exactly 3 cycles after the 4th accept edge.
- Defaults, info 1,1,1,1 (u3,u5,u6,u7=1) -> out_code = 8'h96. Info 0,0,0,1 (u7=1) -> out_code = 8'hFF.
- Macro on, info 1,0,0,0 -> out_code = 8'h55; info 1,1,1,1 -> 8'h96.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in OUT -> out_code/out_valid stable and in_ready=0 throughout, even with in_valid=1 and in_bit toggling.
  - Then out_ready=1 for one cycle -> LOAD, and the next frame encodes correctly (no stale u bits).
- Reset: assert rst for 1 cycle after 2 of 4 info bits, and again during ENC stage 1.
  - Each time, all outputs reach their reset values at that edge.
  - A fresh 4-bit frame 0,0,0,1 then yields 8'hFF.
- Throughput with in_valid gaps:
  - Randomly drop in_valid while out_ready is tied high, over 100 random frames.
  - Every codeword matches the reference model x = u·F^{⊗3}.
  - No frame is lost or duplicated.
